// File: rtl/mc_ctrl_pkg.sv
// Shared types and write-encoding helpers for the memristor array sequencer.
// Imported by the sequencer top and its row decoder.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_SET0,
        S_W_PUL0,
        S_W_SET1,
        S_W_PUL1,
        S_R_CLR,
        S_R_ARM,
        S_R_EVAL,
        S_RESP
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    localparam logic IDLE_DRIVE = 1'b0;

    function automatic logic wr_cbl(input logic d);
        return ~d;
    endfunction

    // Phase 0 programs m0=d, phase 1 programs m1=~d.
    function automatic logic wr_csl(input logic phase, input logic d);
        return phase ? ~d : d;
    endfunction

endpackage

// File: rtl/mc_row_decoder.sv
// Row index to one-hot word lines.
// Even rows land on CWLO, odd rows on CWLE.
module mc_row_decoder
    import mc_ctrl_pkg::*;
#(
    parameter int ROWS = 64
) (
    input  logic [$clog2(ROWS)-1:0] row_i,
    input  logic                    en_i,
    output logic [ROWS/2-1:0]       cwle_o,
    output logic [ROWS/2-1:0]       cwlo_o
);

    localparam int RW = $clog2(ROWS);

    logic [RW-2:0] pair;

    assign pair = row_i[RW-1:1];

    always_comb begin
        cwle_o = {(ROWS/2){IDLE_DRIVE}};
        cwlo_o = {(ROWS/2){IDLE_DRIVE}};
        if (en_i) begin
            if (row_i[0]) cwle_o[pair] = 1'b1;
            else          cwlo_o[pair] = 1'b1;
        end
    end

endmodule

// File: rtl/mc_array_ctrl.sv
// Single-row write/read sequencer for the 64x64 complementary-memristor array.
// Array drives are flopped from the next-state decode so they align with state.
module mc_array_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int ROWS         = 64,
    parameter int COLS         = 64,
    parameter int PULSE_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [$clog2(ROWS)-1:0] req_row,
    input  logic [COLS-1:0]         req_data,
    input  logic [COLS-1:0]         req_mask,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [COLS-1:0]         resp_data,
    output logic                    resp_write,
    output logic [ROWS/2-1:0]       CWLE,
    output logic [ROWS/2-1:0]       CWLO,
    output logic [COLS-1:0]         CBLEN,
    output logic [COLS-1:0]         CBL,
    output logic [COLS-1:0]         CSL,
    output logic [COLS-1:0]         DIN,
    output logic [COLS-1:0]         DINb,
    input  logic [COLS-1:0]         DOUT
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [COLS-1:0] IDLE_COLS = {COLS{IDLE_DRIVE}};

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]     row_q, row_d;
    logic [COLS-1:0]   data_q, data_d;
    logic [COLS-1:0]   mask_q, mask_d;
    logic              resp_valid_q, resp_valid_d;
    logic [COLS-1:0]   resp_data_q, resp_data_d;
    logic              resp_write_q, resp_write_d;
    logic [ROWS/2-1:0] cwle_q, cwle_d;
    logic [ROWS/2-1:0] cwlo_q, cwlo_d;
    logic [COLS-1:0]   cblen_q, cblen_d;
    logic [COLS-1:0]   cbl_q, cbl_d;
    logic [COLS-1:0]   csl_q, csl_d;
    logic [COLS-1:0]   din_q, din_d;
    logic [COLS-1:0]   dinb_q, dinb_d;
    logic              wl_en;
    logic              phase;
    logic              last;

    assign last = (cnt_q == LAST);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        row_d        = row_q;
        data_d       = data_q;
        mask_d       = mask_q;
        resp_data_d  = resp_data_q;
        resp_write_d = resp_write_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    row_d        = req_row;
                    data_d       = req_data;
                    mask_d       = req_mask;
                    resp_data_d  = '0;
                    resp_write_d = req_write;
                    cnt_d        = '0;
                    state_d      = (op_e'(req_write) == OP_WRITE) ? S_W_SET0 : S_R_CLR;
                end
            end
            S_W_SET0: state_d = S_W_PUL0;
            S_W_PUL0: begin
                cnt_d = last ? '0 : cnt_q + 1'b1;
                if (last) state_d = S_W_SET1;
            end
            S_W_SET1: state_d = S_W_PUL1;
            S_W_PUL1: begin
                cnt_d = last ? '0 : cnt_q + 1'b1;
                if (last) state_d = S_RESP;
            end
            S_R_CLR: state_d = S_R_ARM;
            S_R_ARM: begin
                cnt_d = last ? '0 : cnt_q + 1'b1;
                if (last) state_d = S_R_EVAL;
            end
            S_R_EVAL: begin
                cnt_d = last ? '0 : cnt_q + 1'b1;
                if (last) begin
                    state_d     = S_RESP;
                    resp_data_d = DOUT;
                end
            end
            S_RESP: if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wl_en   = 1'b0;
        phase   = 1'b0;
        cblen_d = IDLE_COLS;
        cbl_d   = IDLE_COLS;
        csl_d   = IDLE_COLS;
        din_d   = IDLE_COLS;
        dinb_d  = IDLE_COLS;
        unique case (state_d)
            S_W_SET0, S_W_PUL0, S_W_SET1, S_W_PUL1: begin
                phase   = (state_d == S_W_SET1) || (state_d == S_W_PUL1);
                wl_en   = (state_d == S_W_PUL0) || (state_d == S_W_PUL1);
                cblen_d = mask_d;
                for (int i = 0; i < COLS; i++) begin
                    cbl_d[i] = wr_cbl(data_d[i]);
                    csl_d[i] = wr_csl(phase, data_d[i]);
                end
            end
            S_R_CLR: begin
                csl_d  = '1;
                dinb_d = '1;
            end
            S_R_ARM: begin
                wl_en  = 1'b1;
                csl_d  = '1;
                dinb_d = '1;
            end
            S_R_EVAL: begin
                wl_en  = 1'b1;
                dinb_d = '1;
            end
            default: ;
        endcase
    end

    assign resp_valid_d = (state_d == S_RESP);

    mc_row_decoder #(
        .ROWS(ROWS)
    ) u_row_dec (
        .row_i (row_d),
        .en_i  (wl_en),
        .cwle_o(cwle_d),
        .cwlo_o(cwlo_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            row_q        <= '0;
            data_q       <= '0;
            mask_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_write_q <= 1'b0;
            cwle_q       <= '0;
            cwlo_q       <= '0;
            cblen_q      <= IDLE_COLS;
            cbl_q        <= IDLE_COLS;
            csl_q        <= IDLE_COLS;
            din_q        <= IDLE_COLS;
            dinb_q       <= IDLE_COLS;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            row_q        <= row_d;
            data_q       <= data_d;
            mask_q       <= mask_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_write_q <= resp_write_d;
            cwle_q       <= cwle_d;
            cwlo_q       <= cwlo_d;
            cblen_q      <= cblen_d;
            cbl_q        <= cbl_d;
            csl_q        <= csl_d;
            din_q        <= din_d;
            dinb_q       <= dinb_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_write = resp_write_q;
    assign CWLE       = cwle_q;
    assign CWLO       = cwlo_q;
    assign CBLEN      = cblen_q;
    assign CBL        = cbl_q;
    assign CSL        = csl_q;
    assign DIN        = din_q;
    assign DINb       = dinb_q;

endmodule
